// File: rtl/io_responder_if.sv
// CPU IO bus between the single-cycle core and the MMIO responder.
// The core drives address, write data and strobes; the device returns read data combinationally.
interface io_responder_if;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic        io_rd;
  logic [31:0] io_din;

  modport master (output io_addr, io_dout, io_we, io_rd, input io_din);
  modport slave  (input io_addr, io_dout, io_we, io_rd, output io_din);
endinterface

// File: rtl/io_responder.sv
// MMIO responder: LEDs, 7-seg scan, debounced button/switch capture (IO_OVERRUN_EN adds sticky overrun flag).
// Latency: reads combinational, writes and read side-effects on the next clk edge.
// Backpressure: none on the bus; software polls in_valid / out_ready.
module io_responder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_DIV        = 100000,
  parameter int OUT_BUSY_CYCLES = 8
) (
  input  logic          clk,
  input  logic          rst,
  io_responder_if.slave bus,
  input  logic [15:0]   sw,
  input  logic          btn,
  output logic [15:0]   led,
  output logic [7:0]    an,
  output logic [6:0]    seg
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int SD_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BZ_W = (OUT_BUSY_CYCLES > 1) ? $clog2(OUT_BUSY_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SD_W-1:0] SD_LAST = SD_W'(SCAN_DIV - 1);
  localparam logic [BZ_W-1:0] BZ_LAST = BZ_W'(OUT_BUSY_CYCLES - 1);

  localparam logic [7:0] A_LED        = 8'h00;
  localparam logic [7:0] A_IN_STATUS  = 8'h04;
  localparam logic [7:0] A_IN_DATA    = 8'h08;
  localparam logic [7:0] A_OUT_STATUS = 8'h0C;
  localparam logic [7:0] A_SEG        = 8'h10;

  logic            btn_s1, btn_s2;
  logic [15:0]     sw_s1, sw_s2;
  logic            db_level;
  logic [DB_W-1:0] db_cnt;
  logic [1:0]      sync_fill;
  logic            armed;
  logic            db_rise;
  logic [15:0]     in_data;
  logic            in_valid;
  logic [31:0]     seg_data;
  logic            out_ready;
  logic [BZ_W-1:0] busy_cnt;
  logic [SD_W-1:0] scan_div;
  logic [2:0]      scan_idx;
  logic            overrun_bit;

  logic wr_led, wr_seg, rd_in_data;
  assign wr_led     = bus.io_we && (bus.io_addr == A_LED);
  assign wr_seg     = bus.io_we && (bus.io_addr == A_SEG);
  assign rd_in_data = bus.io_rd && (bus.io_addr == A_IN_DATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  // Counts only while the synchronized level disagrees with the debounced one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else if (btn_s2 == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_level <= btn_s2;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // A button held through reset must be seen released (once the synchronizer
  // holds real samples) before any press is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_fill <= '0;
      armed     <= 1'b0;
    end else begin
      if (!sync_fill[1]) sync_fill <= sync_fill + 2'd1;
      if (sync_fill[1] && !btn_s2) armed <= 1'b1;
    end
  end

  assign db_rise = armed && btn_s2 && !db_level && (db_cnt == DB_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_data  <= '0;
      in_valid <= 1'b0;
    end else if (db_rise && (!in_valid || rd_in_data)) begin
      in_data  <= sw_s2;
      in_valid <= 1'b1;
    end else if (rd_in_data) begin
      in_valid <= 1'b0;
    end
  end

`ifdef IO_OVERRUN_EN
  logic overrun;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       overrun <= 1'b0;
    else if (db_rise && in_valid)  overrun <= 1'b1;
    else if (rd_in_data)           overrun <= 1'b0;
  end
  assign overrun_bit = overrun;
`else
  assign overrun_bit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led      <= '0;
      seg_data <= '0;
    end else begin
      if (wr_led) led      <= bus.io_dout[15:0];
      if (wr_seg) seg_data <= bus.io_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_ready <= 1'b1;
      busy_cnt  <= '0;
    end else if (wr_seg) begin
      out_ready <= 1'b0;
      busy_cnt  <= BZ_LAST;
    end else if (!out_ready) begin
      if (busy_cnt == '0) out_ready <= 1'b1;
      else                busy_cnt  <= busy_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_div <= '0;
      scan_idx <= '0;
    end else if (scan_div == SD_LAST) begin
      scan_div <= '0;
      scan_idx <= scan_idx + 3'd1;
    end else begin
      scan_div <= scan_div + 1'b1;
    end
  end

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h40;  4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;  4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;  4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;  4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;  4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;  4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;  4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;  default: hex_glyph = 7'h0E;
    endcase
  endfunction

  assign an  = ~(8'h01 << scan_idx);
  assign seg = hex_glyph(seg_data[{scan_idx, 2'b00} +: 4]);

  always_comb begin
    bus.io_din = '0;
    if (bus.io_rd) begin
      case (bus.io_addr)
        A_LED:        bus.io_din = {16'b0, led};
        A_IN_STATUS:  bus.io_din = {30'b0, overrun_bit, in_valid};
        A_IN_DATA:    bus.io_din = {16'b0, in_data};
        A_OUT_STATUS: bus.io_din = {31'b0, out_ready};
        A_SEG:        bus.io_din = seg_data;
        default:      bus.io_din = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: bus-op vector table plus hand-written debounce, handshake, scan and reset sequences.
module tb_io_responder;
  logic        clk;
  logic        rst;
  logic [15:0] sw;
  logic        btn;
  logic [15:0] led;
  logic [7:0]  an;
  logic [6:0]  seg;

  io_responder_if bus();

  io_responder #(.DEBOUNCE_CYCLES(4), .SCAN_DIV(2), .OUT_BUSY_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sw(sw), .btn(btn), .led(led), .an(an), .seg(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef IO_OVERRUN_EN
  localparam logic [31:0] OVR = 32'h2;
`else
  localparam logic [31:0] OVR = 32'h0;
`endif

  typedef struct {
    logic        we;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] dout;
    logic [31:0] exp;
  } vec_t;

  int          checks;
  int          failures;
  logic [31:0] sb_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: expectation queued at drive time, io_din popped and compared mid-cycle.
  task automatic bus_op(input logic we, input logic rd, input logic [7:0] addr,
                        input logic [31:0] dout, input logic [31:0] exp, input string name);
    logic [31:0] want;
    bus.io_we   = we;
    bus.io_rd   = rd;
    bus.io_addr = addr;
    bus.io_dout = dout;
    sb_q.push_back(exp);
    @(negedge clk);
    want = sb_q.pop_front();
    check(name, bus.io_din, want);
    tick();
    bus.io_we = 1'b0;
    bus.io_rd = 1'b0;
  endtask

  task automatic press(input logic [15:0] v);
    sw  = v;
    btn = 1'b1;
    repeat (8) tick();
    btn = 1'b0;
    repeat (10) tick();
  endtask

  vec_t        vecs[11];
  logic [6:0]  exp_seg[8];
  logic [7:0]  one8;
  logic [7:0]  prev_an;
  logic        found;
  int          idx;

  initial begin
    checks   = 0;
    failures = 0;
    one8     = 8'h01;
    exp_seg  = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 32'hABCD1234, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 8'h00, 32'h0,        32'h00001234};
    vecs[2]  = '{1'b0, 1'b1, 8'h04, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 1'b1, 8'h0C, 32'h0,        32'h1};
    vecs[4]  = '{1'b0, 1'b1, 8'h10, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 1'b1, 8'h08, 32'h0,        32'h0};
    vecs[6]  = '{1'b0, 1'b1, 8'h14, 32'h0,        32'h0};
    vecs[7]  = '{1'b1, 1'b1, 8'h00, 32'h00005555, 32'h00001234};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 32'h0,        32'h00005555};
    vecs[9]  = '{1'b1, 1'b0, 8'h14, 32'hFFFFFFFF, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 8'h01, 32'h0,        32'h0};

    rst = 1'b0; sw = '0; btn = 1'b0;
    bus.io_we = 1'b0; bus.io_rd = 1'b0; bus.io_addr = '0; bus.io_dout = '0;

    // Reset asserted between edges
    #2 rst = 1'b1;
    #1;
    check("rst_led", {16'b0, led}, 32'h0);
    check("rst_an", {24'b0, an}, 32'hFE);
    check("rst_seg", {25'b0, seg}, 32'h40);
    check("rst_din", bus.io_din, 32'h0);
    bus.io_rd = 1'b1; bus.io_addr = 8'h0C;
    #1 check("rst_out_status", bus.io_din, 32'h1);
    bus.io_rd = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 11; i++) begin
      bus_op(vecs[i].we, vecs[i].rd, vecs[i].addr, vecs[i].dout, vecs[i].exp, $sformatf("vec%0d", i));
      if (i == 0) check("led_port", {16'b0, led}, 32'h00001234);
    end

    // Button capture and glitch rejection
    press(16'h00A5);
    bus_op(0, 1, 8'h04, 0, 32'h1, "in_status_set");
    bus_op(0, 1, 8'h08, 0, 32'h00A5, "in_data_a5");
    bus_op(0, 1, 8'h04, 0, 32'h0, "in_status_clr");
    btn = 1'b1;
    repeat (2) tick();
    btn = 1'b0;
    repeat (10) tick();
    bus_op(0, 1, 8'h04, 0, 32'h0, "glitch_ignored");

    // Output handshake, then reload while busy
    bus_op(1, 0, 8'h10, 32'h87654321, 32'h0, "seg_wr");
    for (int i = 0; i < 3; i++) bus_op(0, 1, 8'h0C, 0, 32'h0, $sformatf("busy%0d", i));
    bus_op(0, 1, 8'h0C, 0, 32'h1, "ready_again");
    bus_op(0, 1, 8'h10, 0, 32'h87654321, "seg_rd");
    bus_op(1, 0, 8'h10, 32'h87654321, 32'h0, "seg_wr_a");
    bus_op(1, 0, 8'h10, 32'h87654321, 32'h0, "seg_wr_b");
    for (int i = 0; i < 3; i++) bus_op(0, 1, 8'h0C, 0, 32'h0, $sformatf("reload_busy%0d", i));
    bus_op(0, 1, 8'h0C, 0, 32'h1, "reload_ready");

    // Scan sequence: align on the 7F->FE wrap, then follow 16 edges
    found   = 1'b0;
    prev_an = an;
    for (int c = 0; c < 64 && !found; c++) begin
      tick();
      if (prev_an == 8'h7F && an == 8'hFE) found = 1'b1;
      prev_an = an;
    end
    check("scan_wrap_found", {31'b0, found}, 32'h1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      idx = (k / 2) % 8;
      check($sformatf("scan_an%0d", k), {24'b0, an}, {24'b0, ~(one8 << idx)});
      check($sformatf("scan_seg%0d", k), {25'b0, seg}, {25'b0, exp_seg[idx]});
    end

    // Second press while valid is dropped
    press(16'h0011);
    press(16'h0022);
    bus_op(0, 1, 8'h04, 0, 32'h1 | OVR, "second_press_status");

    // Capture coinciding with an IN_DATA read: rise lands on the 6th edge after btn
    sw  = 16'h0033;
    btn = 1'b1;
    repeat (5) tick();
    bus_op(0, 1, 8'h08, 0, 32'h0011, "race_rd_old");
    bus_op(0, 1, 8'h04, 0, 32'h1 | OVR, "race_valid_kept");
    btn = 1'b0;
    repeat (10) tick();
    bus_op(0, 1, 8'h08, 0, 32'h0033, "race_new_data");
    bus_op(0, 1, 8'h04, 0, 32'h0, "race_status_clr");

    // Async reset while busy and valid, button held through it
    press(16'h0044);
    bus_op(1, 0, 8'h10, 32'h00000009, 32'h0, "seg_wr_pre_rst");
    btn = 1'b1;
    #3 rst = 1'b1;
    bus.io_rd = 1'b1; bus.io_addr = 8'h0C;
    #1 check("rst2_out_ready", bus.io_din, 32'h1);
    bus.io_addr = 8'h04;
    #1 check("rst2_in_status", bus.io_din, 32'h0);
    check("rst2_seg", {25'b0, seg}, 32'h40);
    bus.io_rd = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (12) tick();
    bus_op(0, 1, 8'h04, 0, 32'h0, "held_thru_rst");
    bus_op(0, 1, 8'h10, 0, 32'h0, "seg_after_rst");
    btn = 1'b0;
    repeat (10) tick();
    press(16'h0055);
    bus_op(0, 1, 8'h04, 0, 32'h1, "repress_status");
    bus_op(0, 1, 8'h08, 0, 32'h0055, "repress_data");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
